idu1: RTL and testbench

- Second decode stage. Consumes the registered decode packet from idu0 and reads the architectural register file.
- Resolves operands using forwarding from EXU and writeback.
- Tracks long-latency destinations (load, mul, div/rem) in a scoreboard and stalls on RAW hazards against them.
- Registers a fully resolved issue packet for EXU.

---
 rtl/idu1_pkg.sv | 46 ++++
 rtl/idu1_if.sv | 42 ++++
 rtl/dff_rst_en_flush.sv | 28 ++
 rtl/idu1_scoreboard.sv | 61 ++++++
 rtl/idu1.sv | 110 +++++++++++
 tb/tb_idu1.sv | 230 +++++++++++++++++++++++
 6 files changed

// File: rtl/idu1_pkg.sv
// idu1_pkg: shared decode/issue packet types and the long-latency op-class helper.
// Revision: 1.0
`default_nettype none

package idu1_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);

  typedef struct packed {
    logic [XLEN-1:0]       instr_tag;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic                  rs1;
    logic                  rs2;
    logic                  rd;
    logic                  imm_valid;
    logic                  pc;
    logic                  condbr;
    logic                  load;
    logic                  store;
    logic                  mul;
    logic                  div;
    logic                  rem;
    logic [3:0]            alu_op;
  } idu0_out_t;

  typedef struct packed {
    logic            valid;
    idu0_out_t       ctrl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] cmp_b;
  } idu1_out_t;

  function automatic logic is_long_lat(input idu0_out_t c);
    return c.load | c.mul | c.div | c.rem;
  endfunction

endpackage

`default_nettype wire

// File: rtl/idu1_if.sv
// idu1_if: decode-in, forwarding, writeback, pipeline-control and issue-out bundle.
// Revision: 1.0
`default_nettype none

interface idu1_if;
  import idu1_pkg::*;

  idu0_out_t             idu0_out;
  logic                  idu0_valid;
  logic [REG_ADDR_W-1:0] rf_rs1_addr;
  logic [REG_ADDR_W-1:0] rf_rs2_addr;
  logic [XLEN-1:0]       rf_rs1_data;
  logic [XLEN-1:0]       rf_rs2_data;
  logic                  ex_fwd_valid;
  logic [REG_ADDR_W-1:0] ex_fwd_rd;
  logic [XLEN-1:0]       ex_fwd_data;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic                  wb_long;
  logic                  pipe_stall;
  logic                  pipe_flush;
  logic                  hazard_stall;
  idu1_out_t             idu1_out;

  modport slave (
    input  idu0_out, idu0_valid, rf_rs1_data, rf_rs2_data,
    input  ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
    input  wb_valid, wb_rd, wb_data, wb_long, pipe_stall, pipe_flush,
    output rf_rs1_addr, rf_rs2_addr, hazard_stall, idu1_out
  );

  modport master (
    output idu0_out, idu0_valid, rf_rs1_data, rf_rs2_data,
    output ex_fwd_valid, ex_fwd_rd, ex_fwd_data,
    output wb_valid, wb_rd, wb_data, wb_long, pipe_stall, pipe_flush,
    input  rf_rs1_addr, rf_rs2_addr, hazard_stall, idu1_out
  );

endinterface

`default_nettype wire

// File: rtl/dff_rst_en_flush.sv
// dff_rst_en_flush: W-bit register with reset, flush-to-zero and load enable (priority in that order).
// Revision: 1.0
`default_nettype none

module dff_rst_en_flush #(
  parameter int W = 1
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_flush,
  input  wire logic         i_en,
  input  wire logic [W-1:0] i_d,
  output logic      [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst)          r_q <= '0;
    else if (i_flush) r_q <= '0;
    else if (i_en)    r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/idu1_scoreboard.sv
// idu1_scoreboard: busy bits for in-flight long-latency destinations, with flush rollback of the last issue.
// Revision: 1.0
`default_nettype none

module idu1_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  wire logic [REG_ADDR_W-1:0] i_rs2_addr,
  input  wire logic [REG_ADDR_W-1:0] i_rd_addr,
  input  wire logic                  i_set_en,
  input  wire logic                  i_load_en,
  input  wire logic                  i_flush,
  input  wire logic                  i_wb_clr,
  input  wire logic [REG_ADDR_W-1:0] i_wb_rd,
  output logic                       o_busy_rs1,
  output logic                       o_busy_rs2,
  output logic                       o_busy_rd
);

  logic [NUM_REGS-1:0]   r_sb;
  logic [NUM_REGS-1:0]   w_sb_next;
  logic                  r_last_long;
  logic [REG_ADDR_W-1:0] r_last_rd;

  // A writeback in the same cycle counts as already cleared, so the consumer wakes immediately.
  assign o_busy_rs1 = r_sb[i_rs1_addr] & ~(i_wb_clr & (i_wb_rd == i_rs1_addr));
  assign o_busy_rs2 = r_sb[i_rs2_addr] & ~(i_wb_clr & (i_wb_rd == i_rs2_addr));
  assign o_busy_rd  = r_sb[i_rd_addr]  & ~(i_wb_clr & (i_wb_rd == i_rd_addr));

  always_comb begin
    w_sb_next = r_sb;
    if (i_wb_clr)              w_sb_next[i_wb_rd]   = 1'b0;
    if (i_flush & r_last_long) w_sb_next[r_last_rd] = 1'b0;
    if (i_set_en)              w_sb_next[i_rd_addr] = 1'b1;
    w_sb_next[0] = 1'b0;
  end

  // last_issue tracks the packet currently sitting in the output flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb        <= '0;
      r_last_long <= 1'b0;
      r_last_rd   <= '0;
    end else begin
      r_sb <= w_sb_next;
      if (i_flush) begin
        r_last_long <= 1'b0;
      end else if (i_load_en) begin
        r_last_long <= i_set_en;
        r_last_rd   <= i_rd_addr;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/idu1.sv
// idu1: second decode stage -- operand read/forwarding, long-latency hazard stall and issue register.
// Revision: 1.0
`default_nettype none

module idu1 #(
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5
) (
  input wire logic clk,
  input wire logic rst,
  idu1_if.slave    bus
);
  import idu1_pkg::*;

  function automatic logic [XLEN-1:0] resolve(
    input logic [REG_ADDR_W-1:0] addr,
    input logic [XLEN-1:0]       rf,
    input logic                  exv,
    input logic [REG_ADDR_W-1:0] exrd,
    input logic [XLEN-1:0]       exd,
    input logic                  wbv,
    input logic [REG_ADDR_W-1:0] wbrd,
    input logic [XLEN-1:0]       wbd
  );
    if (addr == '0)                 return '0;
    else if (exv && exrd == addr)   return exd;
    else if (wbv && wbrd == addr)   return wbd;
    else                            return rf;
  endfunction

  idu0_out_t       w_c;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic            w_long;
  logic            w_wb_clr;
  logic            w_busy_rs1;
  logic            w_busy_rs2;
  logic            w_busy_rd;
  logic            w_hazard;
  logic            w_issue;
  logic            w_set_en;
  idu1_out_t       w_pkt;
  idu1_out_t       w_q;

  assign w_c             = bus.idu0_out;
  assign bus.rf_rs1_addr = w_c.rs1_addr;
  assign bus.rf_rs2_addr = w_c.rs2_addr;

  assign w_rs1_val = resolve(w_c.rs1_addr, bus.rf_rs1_data, bus.ex_fwd_valid, bus.ex_fwd_rd,
                             bus.ex_fwd_data, bus.wb_valid, bus.wb_rd, bus.wb_data);
  assign w_rs2_val = resolve(w_c.rs2_addr, bus.rf_rs2_data, bus.ex_fwd_valid, bus.ex_fwd_rd,
                             bus.ex_fwd_data, bus.wb_valid, bus.wb_rd, bus.wb_data);

  assign w_long   = is_long_lat(w_c);
  assign w_wb_clr = bus.wb_valid & bus.wb_long;

  // Source RAW checks plus WAW on a long op whose destination is still pending.
  assign w_hazard = bus.idu0_valid & ~bus.pipe_flush & ~rst &
                    ((w_c.rs1 & w_busy_rs1) | (w_c.rs2 & w_busy_rs2) |
                     (w_c.rd & w_long & w_busy_rd));
  assign w_issue  = bus.idu0_valid & ~w_hazard & ~bus.pipe_stall & ~bus.pipe_flush;
  assign w_set_en = w_issue & w_c.rd & w_long & (w_c.rd_addr != '0);

  assign bus.hazard_stall = w_hazard;

  always_comb begin
    w_pkt            = '0;
    w_pkt.valid      = w_issue;
    w_pkt.ctrl       = w_c;
    w_pkt.op_a       = w_c.pc ? w_c.instr_tag : w_rs1_val;
    w_pkt.op_b       = (w_c.imm_valid & ~w_c.condbr) ? w_c.imm : w_rs2_val;
    w_pkt.store_data = w_rs2_val;
    w_pkt.cmp_b      = w_rs2_val;
  end

  idu1_scoreboard #(
    .NUM_REGS   (NUM_REGS),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_rs1_addr (w_c.rs1_addr),
    .i_rs2_addr (w_c.rs2_addr),
    .i_rd_addr  (w_c.rd_addr),
    .i_set_en   (w_set_en),
    .i_load_en  (~bus.pipe_stall),
    .i_flush    (bus.pipe_flush),
    .i_wb_clr   (w_wb_clr),
    .i_wb_rd    (bus.wb_rd),
    .o_busy_rs1 (w_busy_rs1),
    .o_busy_rs2 (w_busy_rs2),
    .o_busy_rd  (w_busy_rd)
  );

  dff_rst_en_flush #(
    .W ($bits(idu1_out_t))
  ) u_out (
    .clk     (clk),
    .rst     (rst),
    .i_flush (bus.pipe_flush),
    .i_en    (~bus.pipe_stall),
    .i_d     (w_pkt),
    .o_q     (w_q)
  );

  assign bus.idu1_out = w_q;

endmodule

`default_nettype wire

// File: tb/tb_idu1.sv
// tb_idu1: directed self-checking bench for idu1 (forwarding, scoreboard stalls, flush, stall hold).
// Revision: 1.0
`default_nettype none

module tb_idu1;
  import idu1_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  idu0_out_t p;

  idu1_if bus ();

  idu1 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic idu0_out_t mk_r(input int rd, input int rs1, input int rs2);
    idu0_out_t c;
    c          = '0;
    c.rd_addr  = rd[REG_ADDR_W-1:0];
    c.rs1_addr = rs1[REG_ADDR_W-1:0];
    c.rs2_addr = rs2[REG_ADDR_W-1:0];
    c.rd       = 1'b1;
    c.rs1      = 1'b1;
    c.rs2      = 1'b1;
    return c;
  endfunction

  function automatic idu0_out_t mk_i(input int rd, input int rs1, input logic [XLEN-1:0] imm);
    idu0_out_t c;
    c           = mk_r(rd, rs1, 0);
    c.rs2       = 1'b0;
    c.imm       = imm;
    c.imm_valid = 1'b1;
    return c;
  endfunction

  task automatic drive(input idu0_out_t c, input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2);
    bus.idu0_out    = c;
    bus.idu0_valid  = 1'b1;
    bus.rf_rs1_data = d1;
    bus.rf_rs2_data = d2;
  endtask

  task automatic set_wb(input logic v, input int rd, input logic [XLEN-1:0] d, input logic lng);
    bus.wb_valid = v;
    bus.wb_rd    = rd[REG_ADDR_W-1:0];
    bus.wb_data  = d;
    bus.wb_long  = lng;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.idu0_out     = '0;
    bus.idu0_valid   = 1'b0;
    bus.rf_rs1_data  = '0;
    bus.rf_rs2_data  = '0;
    bus.ex_fwd_valid = 1'b0;
    bus.ex_fwd_rd    = '0;
    bus.ex_fwd_data  = '0;
    set_wb(1'b0, 0, 32'h0, 1'b0);
    bus.pipe_stall   = 1'b0;
    bus.pipe_flush   = 1'b0;

    // Reset with a live packet present
    drive(mk_r(3, 1, 2), 32'd5, 32'd7);
    tick();
    chk("rst_haz", 64'(bus.hazard_stall), 64'd0);
    chk("rst_valid", 64'(bus.idu1_out.valid), 64'd0);
    chk("rst_opa", 64'(bus.idu1_out.op_a), 64'd0);
    tick();
    rst = 1'b0;

    // add x3,x1,x2
    drive(mk_r(3, 1, 2), 32'd5, 32'd7);
    #1;
    chk("rf_addr1", 64'(bus.rf_rs1_addr), 64'd1);
    chk("rf_addr2", 64'(bus.rf_rs2_addr), 64'd2);
    chk("add_haz", 64'(bus.hazard_stall), 64'd0);
    tick();
    chk("add_valid", 64'(bus.idu1_out.valid), 64'd1);
    chk("add_opa", 64'(bus.idu1_out.op_a), 64'd5);
    chk("add_opb", 64'(bus.idu1_out.op_b), 64'd7);
    chk("add_rd", 64'(bus.idu1_out.ctrl.rd_addr), 64'd3);

    // lw x5,0(x1) then add x6,x5,x5
    p = mk_i(5, 1, 32'h0);
    p.load = 1'b1;
    drive(p, 32'd5, 32'd0);
    tick();
    chk("lw_valid", 64'(bus.idu1_out.valid), 64'd1);
    drive(mk_r(6, 5, 5), 32'hDEAD, 32'hDEAD);
    #1;
    chk("raw_haz1", 64'(bus.hazard_stall), 64'd1);
    tick();
    chk("raw_bubble1", 64'(bus.idu1_out.valid), 64'd0);
    chk("raw_haz2", 64'(bus.hazard_stall), 64'd1);
    tick();
    chk("raw_bubble2", 64'(bus.idu1_out.valid), 64'd0);
    set_wb(1'b1, 5, 32'h1234, 1'b1);
    #1;
    chk("wake_haz", 64'(bus.hazard_stall), 64'd0);
    tick();
    chk("wake_valid", 64'(bus.idu1_out.valid), 64'd1);
    chk("wake_opa", 64'(bus.idu1_out.op_a), 64'h1234);
    chk("wake_opb", 64'(bus.idu1_out.op_b), 64'h1234);
    set_wb(1'b0, 0, 32'h0, 1'b0);
    drive(mk_r(6, 5, 5), 32'h1234, 32'h1234);
    #1;
    chk("sb_cleared", 64'(bus.hazard_stall), 64'd0);
    tick();

    // addi x7,x4,1 with EX and WB both targeting x4
    drive(mk_i(7, 4, 32'd1), 32'h11, 32'h0);
    bus.ex_fwd_valid = 1'b1;
    bus.ex_fwd_rd    = 5'd4;
    bus.ex_fwd_data  = 32'hAA;
    set_wb(1'b1, 4, 32'hBB, 1'b0);
    tick();
    chk("fwd_ex_opa", 64'(bus.idu1_out.op_a), 64'hAA);
    chk("fwd_ex_opb", 64'(bus.idu1_out.op_b), 64'd1);
    bus.ex_fwd_valid = 1'b0;
    tick();
    chk("fwd_wb_opa", 64'(bus.idu1_out.op_a), 64'hBB);
    set_wb(1'b0, 0, 32'h0, 1'b0);

    // div x8 then flush; add x9,x8,x0 must not stall afterwards
    p = mk_r(8, 1, 2);
    p.div = 1'b1;
    drive(p, 32'd5, 32'd7);
    tick();
    chk("div_valid", 64'(bus.idu1_out.valid), 64'd1);
    drive(mk_r(9, 8, 0), 32'h88, 32'h77);
    bus.pipe_flush = 1'b1;
    #1;
    chk("flush_haz", 64'(bus.hazard_stall), 64'd0);
    tick();
    chk("flush_valid", 64'(bus.idu1_out.valid), 64'd0);
    bus.pipe_flush = 1'b0;
    #1;
    chk("flush_sb_clr", 64'(bus.hazard_stall), 64'd0);
    tick();
    chk("post_flush_valid", 64'(bus.idu1_out.valid), 64'd1);
    chk("post_flush_opa", 64'(bus.idu1_out.op_a), 64'h88);
    chk("post_flush_opb_x0", 64'(bus.idu1_out.op_b), 64'd0);

    // pc-relative packet with tag 0x100, then held by pipe_stall
    p = mk_i(12, 0, 32'h0);
    p.pc = 1'b1;
    p.instr_tag = 32'h100;
    drive(p, 32'h0, 32'h0);
    tick();
    chk("tag_opa", 64'(bus.idu1_out.op_a), 64'h100);
    p = mk_i(10, 1, 32'd4);
    p.load = 1'b1;
    drive(p, 32'h20, 32'h0);
    bus.pipe_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_valid", 64'(bus.idu1_out.valid), 64'd1);
      chk("hold_opa", 64'(bus.idu1_out.op_a), 64'h100);
    end
    bus.pipe_stall = 1'b0;
    tick();
    chk("release_rd", 64'(bus.idu1_out.ctrl.rd_addr), 64'd10);
    chk("release_opa", 64'(bus.idu1_out.op_a), 64'h20);
    chk("release_opb", 64'(bus.idu1_out.op_b), 64'd4);
    // Same lw again: WAW on pending x10
    #1;
    chk("waw_haz", 64'(bus.hazard_stall), 64'd1);
    set_wb(1'b1, 10, 32'h0, 1'b1);
    #1;
    chk("waw_wake", 64'(bus.hazard_stall), 64'd0);
    tick();
    set_wb(1'b0, 0, 32'h0, 1'b0);
    drive(mk_r(11, 10, 0), 32'h0, 32'h0);
    #1;
    chk("set_wins", 64'(bus.hazard_stall), 64'd1);
    set_wb(1'b1, 10, 32'h55, 1'b1);
    tick();
    chk("x10_opa", 64'(bus.idu1_out.op_a), 64'h55);
    set_wb(1'b0, 0, 32'h0, 1'b0);

    // lw x0 then add x1,x0,x0
    p = mk_i(0, 1, 32'h0);
    p.load = 1'b1;
    drive(p, 32'h3, 32'h0);
    tick();
    drive(mk_r(1, 0, 0), 32'h99, 32'h99);
    #1;
    chk("x0_haz", 64'(bus.hazard_stall), 64'd0);
    tick();
    chk("x0_valid", 64'(bus.idu1_out.valid), 64'd1);
    chk("x0_opa", 64'(bus.idu1_out.op_a), 64'd0);
    chk("x0_opb", 64'(bus.idu1_out.op_b), 64'd0);

    bus.idu0_valid = 1'b0;
    tick();
    chk("idle_valid", 64'(bus.idu1_out.valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
